// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared types and defaults for the serial-in/parallel-out frame controller.
// PARITY state is present only when SIPO_FRAME_CTRL_PARITY_EN is defined.
package sipo_frame_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;
`endif

endpackage

// File: rtl/sipo_shreg.sv
// Serial-in shift register with clear and selectable fill direction.
// MSB_FIRST=1 makes the first bit shifted in end up in q[WIDTH-1].
module sipo_shreg
    import sipo_frame_ctrl_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_shift;

    generate
        if (MSB_FIRST) begin : g_msb
            assign q_shift = {q[WIDTH-2:0], din};
        end else begin : g_lsb
            assign q_shift = {din, q[WIDTH-1:1]};
        end
    endgenerate

    // Clear wins over shift; shift only on qualified bits.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= q_shift;
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: collects WIDTH serial bits into a word with valid/ready.
// Optional even-parity check enabled by macro SIPO_FRAME_CTRL_PARITY_EN.
module sipo_frame_ctrl
    import sipo_frame_ctrl_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             d,
    input  logic             bit_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             sr_clr, sr_en;
    logic [WIDTH-1:0] sr;
    logic             word_ok;
    logic             load;

    sipo_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST != 0)
    ) u_shreg (
        .clk (clk),
        .rst (rst),
        .clr (sr_clr),
        .en  (sr_en),
        .din (d),
        .q   (sr)
    );

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    logic perr, perr_nx;

    // Parity verdict is held from the PARITY sample into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr <= 1'b0;
        end else begin
            perr <= perr_nx;
        end
    end

    assign word_ok = (state == DONE) && !perr;
    assign par_err = !rst && (state == DONE) && perr;
`else
    assign word_ok = (state == DONE);
    assign par_err = 1'b0;
`endif

    // State and bit counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state and shift-register control.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sr_clr   = 1'b0;
        sr_en    = 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        perr_nx  = perr;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                    sr_clr   = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    sr_en  = 1'b1;
                    cnt_nx = cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_FRAME_CTRL_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = DONE;
`endif
                    end
                end
            end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            PARITY: begin
                if (bit_en) begin
                    perr_nx  = (^sr) ^ d;
                    state_nx = DONE;
                end
            end
`endif
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign load    = word_ok && (!dout_valid || dout_ready);
    assign overrun = !rst && word_ok && dout_valid && !dout_ready;
    assign busy    = !rst && (state != IDLE);

    // Output word register with valid/ready handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (load) begin
            dout       <= sr;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule
